// File: rtl/duty_ctrl_if.sv
// duty_ctrl_if: switch inputs and duty/BCD outputs of the duty-cycle
// control stage, bundled so the PWM top and the bench share one definition.
//   master : drives the raw switches, observes duty/BCD (board top, bench)
//   slave  : the duty_ctrl block itself
interface duty_ctrl_if;
  logic       sw_on;     // raw SW[0], 1 = output enabled
  logic       sw_up;     // raw SW[1], rising edge -> duty += STEP
  logic       sw_down;   // raw SW[2], rising edge -> duty -= STEP
  logic       pwm_en;    // debounced sw_on
  logic [6:0] duty;      // duty in percent
  logic [3:0] bcd_hund;  // BCD digits of duty for HEX2..HEX0
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       duty_upd;  // one-cycle pulse with new BCD digits

  modport master (output sw_on, sw_up, sw_down,
                  input  pwm_en, duty, bcd_hund, bcd_tens, bcd_ones, duty_upd);
  modport slave  (input  sw_on, sw_up, sw_down,
                  output pwm_en, duty, bcd_hund, bcd_tens, bcd_ones, duty_upd);
endinterface

// File: rtl/duty_ctrl.sv
// duty_ctrl: upstream control for the PWM block.
//   Synchronizes and debounces the on/up/down switches, turns up/down
//   debounced rising edges into +/-STEP events on a saturating duty register
//   (percent), and registers its BCD digits with a one-cycle update pulse.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every flop
//   io_bus : duty_ctrl_if.slave (switches in; pwm_en, duty, bcd_*, duty_upd out)
module duty_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,   // >= 2
  parameter int STEP            = 10,
  parameter int MAX_DUTY        = 100  // <= 127
) (
  input  logic        clk,
  input  logic        rst_n,
  duty_ctrl_if.slave  io_bus
);
  localparam int NUM_SW = 3;  // bit 0 = on, 1 = up, 2 = down
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_SW-1:0]         w_raw;
  logic [NUM_SW-1:0]         r_sync1, r_sync2;
  logic [NUM_SW-1:0]         r_deb, r_deb_d;
  logic [NUM_SW-1:0][CW-1:0] r_cnt;

  logic       w_up_evt, w_dn_evt;
  logic [7:0] w_sum;
  logic [6:0] w_duty_nxt;
  logic [6:0] r_duty;
  logic [3:0] w_hund, w_tens, w_ones;
  logic [3:0] r_hund, r_tens, r_ones;
  // [0]: duty changed this edge, [1]: new digits are on the BCD outputs
  logic [1:0] r_vld_pipe;

  assign w_raw = {io_bus.sw_down, io_bus.sw_up, io_bus.sw_on};

  // Two-flop synchronizer, then an independent debounce channel per switch.
  // The counter only runs while sync disagrees with deb, so deb follows
  // after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < NUM_SW; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES-1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_up_evt = r_deb[1] & ~r_deb_d[1];
  assign w_dn_evt = r_deb[2] & ~r_deb_d[2];

  // 8-bit sum so duty+STEP cannot wrap before the saturation compare.
  assign w_sum = {1'b0, r_duty} + 8'(STEP);

  always_comb begin
    w_duty_nxt = r_duty;
    if (r_deb[0]) begin
      if (w_up_evt && !w_dn_evt)
        w_duty_nxt = (w_sum > 8'(MAX_DUTY)) ? 7'(MAX_DUTY) : w_sum[6:0];
      else if (w_dn_evt && !w_up_evt)
        w_duty_nxt = (r_duty < 7'(STEP)) ? 7'd0 : r_duty - 7'(STEP);
    end
  end

  // Digits are recomputed every cycle; they only differ after duty moved.
  always_comb begin
    w_hund = 4'(r_duty / 7'd100);
    w_tens = 4'((r_duty / 7'd10) % 7'd10);
    w_ones = 4'(r_duty % 7'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty     <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_duty     <= w_duty_nxt;
      r_hund     <= w_hund;
      r_tens     <= w_tens;
      r_ones     <= w_ones;
      // saturated requests leave duty equal, so no pulse follows
      r_vld_pipe <= {r_vld_pipe[0], (w_duty_nxt != r_duty)};
    end
  end

  assign io_bus.pwm_en   = r_deb[0];
  assign io_bus.duty     = r_duty;
  assign io_bus.bcd_hund = r_hund;
  assign io_bus.bcd_tens = r_tens;
  assign io_bus.bcd_ones = r_ones;
  assign io_bus.duty_upd = r_vld_pipe[1];
endmodule
